// File: rtl/crush_wb_pkg.sv
// Shared Wishbone B4 encodings and burst address helper.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package crush_wb_pkg;

  // Cycle type identifier (cti_i)
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  // Burst type extension (bte_i)
  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIC_ACK,
    ST_BURST
  } wb_state_e;

  // Next word index of a burst: linear bursts carry into the full index,
  // wrapping bursts only roll the low 2/3/4 bits and keep the block fixed.
  function automatic logic [31:0] burst_next(input logic [31:0] word, input logic [1:0] bte);
    logic [31:0] inc;
    logic [31:0] nxt;
    inc = word + 32'd1;
    nxt = inc;
    case (bte)
      BTE_WRAP4:  nxt = {word[31:2], inc[1:0]};
      BTE_WRAP8:  nxt = {word[31:3], inc[2:0]};
      BTE_WRAP16: nxt = {word[31:4], inc[3:0]};
      default:    nxt = inc;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wb_ram_bytewise.sv
// Simple dual-port RAM: one byte-enabled write port, one synchronous read port.
// Latency: read data valid one clock after raddr_i is sampled.
// Backpressure: none; accepts a write and a read every cycle. Not reset.
module wb_ram_bytewise #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Byte-lane gated write; an all-zero be_i leaves the word untouched.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port, kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

  // Taps on the first eight words for waveform viewing; no logic reads them.
  logic [DW-1:0] word0_unused, word1_unused, word2_unused, word3_unused;
  logic [DW-1:0] word4_unused, word5_unused, word6_unused, word7_unused;
  assign word0_unused = mem_q[0];
  assign word1_unused = mem_q[1];
  assign word2_unused = mem_q[2];
  assign word3_unused = mem_q[3];
  assign word4_unused = mem_q[4];
  assign word5_unused = mem_q[5];
  assign word6_unused = mem_q[6];
  assign word7_unused = mem_q[7];

endmodule

// File: rtl/wb_burst_memory.sv
// Wishbone B4 slave memory with classic and incrementing/wrapping burst support.
// Latency: termination one cycle after the request; bursts then stream one beat per cycle.
// Backpressure: classic accesses insert one idle cycle; bursts never stall, out-of-range beats end with err_o.
module wb_burst_memory
  import crush_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          SIZE         = 1024,
  parameter int          DATA_WIDTH   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [31:0]             adr_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o
);

  localparam int          OFF     = $clog2(DATA_WIDTH/8);
  localparam int          AW      = $clog2(SIZE);
  localparam logic [31:0] DEPTH_W = 32'(SIZE);

  wb_state_e state_q, state_d;
  logic      ack_q, ack_d;
  logic      err_q, err_d;
  logic [31:0] bword_q, bword_d;   // word index of the burst beat being acked

  logic        req;
  logic [31:0] req_off;
  logic [31:0] req_word;
  logic        req_hit;
  logic [31:0] bnext;
  logic        bnext_hit;
  logic        beat_wr;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;

  assign req      = cyc_i & stb_i;
  // Addresses below the base wrap to a huge offset and so fall out of range.
  assign req_off  = adr_i - BASE_ADDRESS;
  assign req_word = req_off >> OFF;
  assign req_hit  = req_word < DEPTH_W;

  assign bnext     = burst_next(bword_q, bte_i);
  assign bnext_hit = bnext < DEPTH_W;

  // A write commits on the edge that closes an acked, still-strobed beat.
  assign beat_wr = ack_q & req & we_i;
  assign waddr   = (state_q == ST_BURST) ? bword_q[AW-1:0] : req_word[AW-1:0];
  // During a burst the RAM is read one beat ahead so data streams without bubbles.
  assign raddr   = (state_q == ST_BURST) ? bnext[AW-1:0]   : req_word[AW-1:0];

  wb_ram_bytewise #(
    .DW    (DATA_WIDTH),
    .DEPTH (SIZE),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (beat_wr),
    .be_i    (sel_i),
    .waddr_i (waddr),
    .wdata_i (dat_i),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // Next-state and termination decode.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    bword_d = bword_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (cti_i == CTI_INCR && req_hit) begin
            state_d = ST_BURST;
            ack_d   = 1'b1;
            bword_d = req_word;
          end else begin
            // Classic access, or a burst that starts out of range.
            state_d = ST_CLASSIC_ACK;
            ack_d   = req_hit;
            err_d   = ~req_hit;
          end
        end
      end
      ST_CLASSIC_ACK: begin
        // The master is still strobing while it samples the termination.
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (!req || cti_i == CTI_EOB) begin
          state_d = ST_IDLE;
        end else begin
          bword_d = bnext;
          if (bnext_hit) begin
            ack_d = 1'b1;
          end else begin
            // Error terminates that beat; leave through the one-cycle state.
            err_d   = 1'b1;
            state_d = ST_CLASSIC_ACK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered terminations.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      bword_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      bword_q <= bword_d;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = 1'b0;
  assign dat_o = ack_q ? rdata : '0;

endmodule

// File: tb/tb_wb_burst_memory.sv
`timescale 1ns/1ps
module tb_wb_burst_memory;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          SIZE = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] adr   = '0;
  logic [3:0]  sel   = '0;
  logic [31:0] dat_w = '0;
  logic [2:0]  cti   = '0;
  logic [1:0]  bte   = '0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t        expq[$];
  exp_t        mx;
  int          total = 0;
  int          bad   = 0;
  int          nterm = 0;
  logic [31:0] wbuf[16];
  logic [31:0] ebuf[16];

  always #5 clk = ~clk;

  wb_burst_memory #(
    .BASE_ADDRESS (BASE),
    .SIZE         (SIZE),
    .DATA_WIDTH   (32)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cyc_i  (cyc),
    .stb_i  (stb),
    .we_i   (we),
    .adr_i  (adr),
    .sel_i  (sel),
    .dat_i  (dat_w),
    .cti_i  (cti),
    .bte_i  (bte),
    .dat_o  (dat_o),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .rty_o  (rty_o)
  );

  // Monitor: every termination pops one expectation; idle cycles must show zero data.
  always @(negedge clk) begin
    if (ack_o || err_o) begin
      total++;
      nterm++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_term #%0d: ack=%b err=%b dat=%h, want no termination", nterm, ack_o, err_o, dat_o);
      end else begin
        mx = expq.pop_front();
        if (ack_o !== ~mx.err || err_o !== mx.err || rty_o !== 1'b0 || (mx.chk && dat_o !== mx.dat)) begin
          bad++;
          $display("FAIL term #%0d: ack=%b err=%b rty=%b dat=%h, want ack=%b err=%b rty=0 dat=%h%s",
                   nterm, ack_o, err_o, rty_o, dat_o, ~mx.err, mx.err, mx.dat, mx.chk ? "" : " (unchecked)");
        end
      end
    end else begin
      total++;
      if (dat_o !== 32'h0 || rty_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs: dat=%h rty=%b, want dat=0 rty=0", dat_o, rty_o);
      end
    end
  end

  // Wait for a termination; lat counts negedges from the call, 99 on timeout.
  task automatic wait_term(output int lat, output bit e);
    lat = 99;
    e   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack_o || err_o) begin
        lat = k;
        e   = err_o;
        return;
      end
    end
  endtask

  task automatic chk_lat(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s latency: got %0d negedges, want %0d", nm, got, want);
    end
  endtask

  // Classic single access; exp_err selects err expectation, reads expect exp_d.
  task automatic classic(input bit wr, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [2:0] c, input bit exp_err,
                         input logic [31:0] exp_d, input string nm);
    int lat;
    bit e;
    if (exp_err)  expq.push_back('{err: 1'b1, chk: 1'b1, dat: 32'h0});
    else if (wr)  expq.push_back('{err: 1'b0, chk: 1'b0, dat: 32'h0});
    else          expq.push_back('{err: 1'b0, chk: 1'b1, dat: exp_d});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = s; dat_w = d; cti = c; bte = 2'b00;
    wait_term(lat, e);
    chk_lat(nm, lat, 2);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  function automatic int nxt(input int w, input logic [1:0] b);
    int m;
    case (b)
      2'd1:    m = 3;
      2'd2:    m = 7;
      2'd3:    m = 15;
      default: m = 0;
    endcase
    if (m == 0) return w + 1;
    return (w & ~m) | ((w + 1) & m);
  endfunction

  // Burst of n beats from word w0; beats at index >= n_ok are expected to end in err.
  // Write data comes from wbuf[], read expectations from ebuf[].
  task automatic burst(input bit wr, input int w0, input logic [1:0] b, input int n,
                       input int n_ok, input string nm);
    int w, lat;
    bit e;
    for (int i = 0; i < n; i++) begin
      if (i >= n_ok) begin
        expq.push_back('{err: 1'b1, chk: 1'b1, dat: 32'h0});
        break;
      end
      if (wr) expq.push_back('{err: 1'b0, chk: 1'b0, dat: 32'h0});
      else    expq.push_back('{err: 1'b0, chk: 1'b1, dat: ebuf[i]});
    end
    w = w0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; sel = 4'hF; bte = b;
    adr = BASE + 32'(w) * 4; dat_w = wbuf[0];
    cti = (n == 1) ? 3'b111 : 3'b010;
    for (int i = 0; i < n; i++) begin
      wait_term(lat, e);
      chk_lat($sformatf("%s beat%0d", nm, i), lat, (i == 0) ? 2 : 1);
      @(posedge clk); #1;
      if (e || i == n - 1 || lat > 8) break;
      w = nxt(w, b);
      adr   = BASE + 32'(w) * 4;
      dat_w = wbuf[i + 1];
      cti   = (i + 1 == n - 1) ? 3'b111 : 3'b010;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  initial begin
    int lat;
    bit e;
    #1 rst_n = 1'b0;
    #11;
    total++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || rty_o !== 1'b0 || dat_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: ack=%b err=%b rty=%b dat=%h, want all 0", ack_o, err_o, rty_o, dat_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Classic write/read and byte-lane gating
    classic(1, BASE + 4, 4'hF,    32'hDEAD_BEEF, 3'b000, 0, 32'h0,         "wr_beef");
    classic(0, BASE + 4, 4'hF,    32'h0,         3'b000, 0, 32'hDEAD_BEEF, "rd_beef");
    classic(1, BASE + 4, 4'b0010, 32'h0000_AA00, 3'b000, 0, 32'h0,         "wr_lane1");
    classic(0, BASE + 4, 4'hF,    32'h0,         3'b000, 0, 32'hDEAD_AAEF, "rd_lane1");
    classic(1, BASE + 4, 4'b0000, 32'h1234_5678, 3'b000, 0, 32'h0,         "wr_sel0");
    classic(0, BASE + 4, 4'hF,    32'h0,         3'b000, 0, 32'hDEAD_AAEF, "rd_sel0");
    classic(0, BASE + 7, 4'hF,    32'h0,         3'b000, 0, 32'hDEAD_AAEF, "rd_lowbits");

    // Linear burst write words 0..3, then linear and wrap-4 reads
    wbuf[0] = 32'hA000_0000; wbuf[1] = 32'hA111_1111; wbuf[2] = 32'hA222_2222; wbuf[3] = 32'hA333_3333;
    burst(1, 0, 2'b00, 4, 4, "bw_lin");
    ebuf[0] = 32'hA000_0000; ebuf[1] = 32'hA111_1111; ebuf[2] = 32'hA222_2222; ebuf[3] = 32'hA333_3333;
    burst(0, 0, 2'b00, 4, 4, "br_lin");
    ebuf[0] = 32'hA222_2222; ebuf[1] = 32'hA333_3333; ebuf[2] = 32'hA000_0000; ebuf[3] = 32'hA111_1111;
    burst(0, 2, 2'b01, 4, 4, "br_wrap4");

    // Wrap-8 write from word 6 visits 6,7,0..5; read back linearly
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hB000_0000 | 32'((6 + i) % 8);
    burst(1, 6, 2'b10, 8, 8, "bw_wrap8");
    for (int i = 0; i < 8; i++) ebuf[i] = 32'hB000_0000 | 32'(i);
    burst(0, 0, 2'b00, 8, 8, "br_lin8");

    // Out-of-range classic accesses
    classic(0, BASE + 32'h40, 4'hF, 32'h0,       3'b000, 1, 32'h0, "rd_past_end");
    classic(0, BASE - 4,      4'hF, 32'h0,       3'b000, 1, 32'h0, "rd_below_base");
    classic(1, BASE + 32'h44, 4'hF, 32'hFFFF_FFFF, 3'b000, 1, 32'h0, "wr_past_end");

    // Wrap-16 write from word 14 visits 14,15,0,1
    wbuf[0] = 32'hC000_000E; wbuf[1] = 32'hC000_000F; wbuf[2] = 32'hC000_0000; wbuf[3] = 32'hC000_0001;
    burst(1, 14, 2'b11, 4, 4, "bw_wrap16");
    // Linear burst running off the end: two acks then err
    ebuf[0] = 32'hC000_000E; ebuf[1] = 32'hC000_000F;
    burst(0, 14, 2'b00, 4, 2, "br_cross_end");
    classic(0, BASE + 0, 4'hF, 32'h0, 3'b011, 0, 32'hC000_0000, "rd_cti011");
    classic(0, BASE + 8, 4'hF, 32'h0, 3'b000, 0, 32'hB000_0002, "rd_word2");

    // Reset during beat 2 of a linear burst read
    expq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'hC000_0000});
    expq.push_back('{err: 1'b0, chk: 1'b1, dat: 32'hC000_0001});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; bte = 2'b00; cti = 3'b010; adr = BASE;
    wait_term(lat, e);
    chk_lat("rst_burst beat0", lat, 2);
    @(posedge clk); #1 adr = BASE + 4;
    wait_term(lat, e);
    chk_lat("rst_burst beat1", lat, 1);
    @(posedge clk); #1 adr = BASE + 8;
    rst_n = 1'b0;
    #1;
    total++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || rty_o !== 1'b0 || dat_o !== 32'h0) begin
      bad++;
      $display("FAIL mid_burst_reset: ack=%b err=%b rty=%b dat=%h, want all 0", ack_o, err_o, rty_o, dat_o);
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    classic(0, BASE + 4, 4'hF, 32'h0, 3'b000, 0, 32'hC000_0001, "rd_after_reset");
    ebuf[0] = 32'hB000_0002; ebuf[1] = 32'hB000_0003;
    burst(0, 2, 2'b00, 2, 2, "br_after_reset");

    repeat (4) @(posedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL missing_terms: %0d expected terminations never seen, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
